// File: rtl/approx_sweep_pkg.sv
// Shared state encoding and width helpers for the approximate-adder sweep controller.
package approx_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sweep_state_t;

   // err_count must hold 2^(2*width); sum_ed must hold 2^(2*width)*(2^width-1).
   function automatic int cnt_w(input int width);
      return 2 * width + 1;
   endfunction

   function automatic int sum_w(input int width);
      return 3 * width;
   endfunction

endpackage

// File: rtl/err_metric_acc.sv
// Error-metric accumulators: count of erroneous pairs, worst and summed error distance.
module err_metric_acc
   import approx_sweep_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CNT_W = cnt_w(WIDTH),
   localparam int SUM_W = sum_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] ed,
   output logic [CNT_W-1:0] err_count,
   output logic [WIDTH-1:0] max_ed,
   output logic [SUM_W-1:0] sum_ed
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         err_count <= '0;
         max_ed    <= '0;
         sum_ed    <= '0;
      end else if (en) begin
         if (ed != '0) begin
            err_count <= err_count + CNT_W'(1);
         end
         if (ed > max_ed) begin
            max_ed <= ed;
         end
         sum_ed <= sum_ed + SUM_W'(ed);
      end
   end

endmodule

// File: rtl/approx_adder_sweep_ctrl.sv
// Exhaustive sweep sequencer: walks every (a, b) pair through an approximate adder,
// compares against the exact sum, accumulates error metrics and streams per-pair results.
module approx_adder_sweep_ctrl
   import approx_sweep_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CNT_W = cnt_w(WIDTH),
   localparam int SUM_W = sum_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] approx_sum,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_a,
   output logic [WIDTH-1:0] res_b,
   output logic [WIDTH-1:0] res_approx,
   output logic [WIDTH-1:0] res_exact,
   output logic [CNT_W-1:0] err_count,
   output logic [WIDTH-1:0] max_ed,
   output logic [SUM_W-1:0] sum_ed
);

   sweep_state_t state_reg, state_next;

   logic             capture;
   logic             acc_clear;
   logic             op_load;
   logic             res_clear;
   logic             last_pair;
   logic [WIDTH-1:0] exact;
   logic [WIDTH-1:0] ed;

   // Carry-out dropped so the reference matches the WIDTH-bit sum of the adder.
   assign exact     = op_a + op_b;
   assign ed        = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);
   assign last_pair = (&op_a) && (&op_b);

   assign busy = (state_reg == RUN) || (state_reg == DRAIN);
   assign done = (state_reg == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      acc_clear  = 1'b0;
      op_load    = 1'b0;
      res_clear  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               acc_clear  = 1'b1;
               op_load    = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            // Abort wins over a capture on the same edge.
            if (abort) begin
               res_clear  = 1'b1;
               state_next = IDLE;
            end else if (!(res_valid && !res_ready)) begin
               capture = 1'b1;
               if (last_pair) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               res_clear  = 1'b1;
               state_next = IDLE;
            end else if (res_valid && res_ready) begin
               res_clear  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // a-major, b-minor operand walk; operands park on the last pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a <= '0;
         op_b <= '0;
      end else if (op_load) begin
         op_a <= '0;
         op_b <= '0;
      end else if (capture && !last_pair) begin
         op_b <= op_b + 1'b1;
         if (&op_b) begin
            op_a <= op_a + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid  <= 1'b0;
         res_a      <= '0;
         res_b      <= '0;
         res_approx <= '0;
         res_exact  <= '0;
      end else if (capture) begin
         res_valid  <= 1'b1;
         res_a      <= op_a;
         res_b      <= op_b;
         res_approx <= approx_sum;
         res_exact  <= exact;
      end else if (res_clear) begin
         res_valid  <= 1'b0;
      end
   end

   err_metric_acc #(
      .WIDTH (WIDTH)
   ) u_metrics (
      .clk       (clk),
      .rst       (rst),
      .clear     (acc_clear),
      .en        (capture),
      .ed        (ed),
      .err_count (err_count),
      .max_ed    (max_ed),
      .sum_ed    (sum_ed)
   );

endmodule

// File: tb/tb_approx_adder_sweep_ctrl.sv
// Bench for approx_adder_sweep_ctrl: a 4-bit instance (full sweeps, stalls, abort, reset)
// and a 2-bit instance with an OR-based adder stub.
module tb_approx_adder_sweep_ctrl;

   localparam int N4 = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // 4-bit instance
   logic       start4, abort4, res_ready4;
   logic       busy4, done4, res_valid4;
   logic [3:0] op_a4, op_b4, approx4, res_a4, res_b4, res_approx4, res_exact4, max_ed4;
   logic [8:0] err_count4;
   logic [11:0] sum_ed4;
   int         mode4;

   assign approx4 = (mode4 == 0) ? (op_a4 + op_b4) : ((op_a4 + op_b4) & 4'b1110);

   approx_adder_sweep_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4), .busy(busy4), .done(done4),
      .op_a(op_a4), .op_b(op_b4), .approx_sum(approx4), .res_valid(res_valid4),
      .res_ready(res_ready4), .res_a(res_a4), .res_b(res_b4), .res_approx(res_approx4),
      .res_exact(res_exact4), .err_count(err_count4), .max_ed(max_ed4), .sum_ed(sum_ed4)
   );

   // 2-bit instance
   logic       start2, abort2, res_ready2;
   logic       busy2, done2, res_valid2;
   logic [1:0] op_a2, op_b2, approx2, res_a2, res_b2, res_approx2, res_exact2, max_ed2;
   logic [4:0] err_count2;
   logic [5:0] sum_ed2;

   assign approx2 = op_a2 | op_b2;

   approx_adder_sweep_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
      .op_a(op_a2), .op_b(op_b2), .approx_sum(approx2), .res_valid(res_valid2),
      .res_ready(res_ready2), .res_a(res_a2), .res_b(res_b2), .res_approx(res_approx2),
      .res_exact(res_exact2), .err_count(err_count2), .max_ed(max_ed2), .sum_ed(sum_ed2)
   );

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Behavioural model: expected stream element k and cumulative metrics over pairs 0..k.
   int m_err[N4];
   int m_max[N4];
   int m_sum[N4];

   function automatic int stub_model(input int mode, input int a, input int b);
      int e;
      e = (a + b) % 16;
      return (mode == 0) ? e : (e & 14);
   endfunction

   task automatic build_model(input int mode);
      int ce, cm, cs, a, b, e, ap, d;
      ce = 0; cm = 0; cs = 0;
      for (int k = 0; k < N4; k++) begin
         a  = k / 16;
         b  = k % 16;
         e  = (a + b) % 16;
         ap = stub_model(mode, a, b);
         d  = (e > ap) ? e - ap : ap - e;
         if (d != 0) ce++;
         if (d > cm) cm = d;
         cs += d;
         m_err[k] = ce;
         m_max[k] = cm;
         m_sum[k] = cs;
      end
   endtask

   // Scoreboard: every presented result must be the next pair in order, with matching metrics.
   int sb_k = 0;
   bit sb_en = 1'b0;

   always @(negedge clk) begin
      int a, b, e, ap;
      longint exp_res, act_res, exp_met, act_met;
      if (sb_en && res_valid4) begin
         if (sb_k >= N4) begin
            chk("stream_overrun", sb_k, N4 - 1);
         end else begin
            a  = sb_k / 16;
            b  = sb_k % 16;
            e  = (a + b) % 16;
            ap = stub_model(mode4, a, b);
            exp_res = longint'(a) * 4096 + longint'(b) * 256 + longint'(e) * 16 + longint'(ap);
            act_res = longint'({res_a4, res_b4, res_exact4, res_approx4});
            chk($sformatf("res[%0d] {a,b,exact,approx}", sb_k), act_res, exp_res);
            exp_met = longint'(m_err[sb_k]) * 65536 + longint'(m_max[sb_k]) * 4096 + longint'(m_sum[sb_k]);
            act_met = longint'({err_count4, max_ed4, sum_ed4});
            chk($sformatf("metrics[%0d] {err,max,sum}", sb_k), act_met, exp_met);
         end
         if (res_ready4) sb_k++;
      end
   end

   int done_cnt4 = 0;
   always @(negedge clk) if (done4) done_cnt4++;

   // Sink for the 4-bit instance: 0 = always ready, 1 = random with a 5-cycle stall on (0,10),
   // 2 = ready except when the final pair is presented (holds the DUT in DRAIN).
   int ready_mode = 0;
   int stall_left = 0;
   bit stalled = 1'b0;

   initial begin
      res_ready4 = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: begin
               if (stall_left > 0) begin
                  res_ready4 = 1'b0;
                  stall_left--;
               end else if (!stalled && res_valid4 && res_a4 == 4'd0 && res_b4 == 4'd10) begin
                  res_ready4 = 1'b0;
                  stall_left = 4;
                  stalled    = 1'b1;
               end else begin
                  res_ready4 = ($urandom_range(3) != 0);
               end
            end
            2: res_ready4 = !(res_valid4 && res_a4 == 4'd15 && res_b4 == 4'd15);
            default: res_ready4 = 1'b1;
         endcase
      end
   end

   // 2-bit sink collects the pairs whose approximate sum was wrong.
   int acc2 = 0;
   int fails2[$];
   always @(negedge clk) begin
      if (res_valid2 && res_ready2) begin
         acc2++;
         if (res_approx2 != res_exact2) fails2.push_back(int'(res_a2) * 4 + int'(res_b2));
      end
   end

   task automatic start4_pulse();
      @(posedge clk);
      #1 start4 = 1'b1;
      sb_k  = 0;
      sb_en = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
   endtask

   task automatic sweep4(input string tag, output int done_cyc);
      int c;
      start4_pulse();
      done_cyc = -1;
      c = 0;
      while (c < 5000) begin
         @(negedge clk);
         if (done4) begin
            done_cyc = c;
            break;
         end
         @(posedge clk);
         c++;
      end
      chk({tag, "_done_seen"}, longint'(done_cyc >= 0), 1);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done4, 0);
      chk({tag, "_busy_after"}, busy4, 0);
      chk({tag, "_accepted"}, sb_k, N4);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctl"}, longint'({busy4, done4, res_valid4}), 0);
      chk({tag, "_ops"}, longint'({op_a4, op_b4}), 0);
      chk({tag, "_res"}, longint'({res_a4, res_b4, res_approx4, res_exact4}), 0);
      chk({tag, "_metrics"}, longint'({err_count4, max_ed4, sum_ed4}), 0);
   endtask

   initial begin
      int dcyc, c, found, dc;
      int exp2[7];
      exp2 = '{5, 7, 10, 11, 13, 14, 15};
      rst = 1'b1; start4 = 1'b0; abort4 = 1'b0; mode4 = 0;
      start2 = 1'b0; abort2 = 1'b0; res_ready2 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      chk("reset_w2", longint'({busy2, res_valid2, err_count2, sum_ed2}), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // 2-bit sweep with OR stub
      @(posedge clk);
      #1 start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      dcyc = -1;
      c = 0;
      while (c < 200) begin
         @(negedge clk);
         if (done2) begin dcyc = c; break; end
         @(posedge clk);
         c++;
      end
      chk("w2_done_cycle", dcyc, 17);
      chk("w2_err_count", err_count2, 7);
      chk("w2_max_ed", max_ed2, 3);
      chk("w2_sum_ed", sum_ed2, 14);
      chk("w2_accepted", acc2, 16);
      chk("w2_fail_cnt", fails2.size(), 7);
      for (int i = 0; i < 7 && i < fails2.size(); i++)
         chk($sformatf("w2_fail_pair[%0d]", i), fails2[i], exp2[i]);

      // Run A: exact stub, ready high
      mode4 = 0; ready_mode = 0; build_model(0);
      sweep4("A", dcyc);
      chk("A_done_cycle", dcyc, 257);
      chk("A_metrics", longint'({err_count4, max_ed4, sum_ed4}), 0);

      // Run B: LSB-dropping stub, ready high
      mode4 = 1; build_model(1);
      sweep4("B", dcyc);
      chk("B_done_cycle", dcyc, 257);
      chk("B_err_count", err_count4, 128);
      chk("B_max_ed", max_ed4, 1);
      chk("B_sum_ed", sum_ed4, 128);
      repeat (4) @(negedge clk);
      chk("B_metrics_hold", longint'({err_count4, max_ed4, sum_ed4}), longint'(128) * 65536 + 1 * 4096 + 128);

      // Run C: same stub, stall on (0,10) plus random ready
      stalled = 1'b0; stall_left = 0; ready_mode = 1;
      sweep4("C", dcyc);
      chk("C_stall_applied", stalled, 1);
      chk("C_err_count", err_count4, 128);
      chk("C_max_ed", max_ed4, 1);
      chk("C_sum_ed", sum_ed4, 128);

      // Run D: abort while (3,7) is presented
      ready_mode = 0;
      @(posedge clk);
      start4_pulse();
      found = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (res_valid4 && res_a4 == 4'd3 && res_b4 == 4'd7) begin found = 1; break; end
      end
      chk("D_pair_3_7_seen", found, 1);
      abort4 = 1'b1;
      @(posedge clk);
      #1 abort4 = 1'b0;
      dc = done_cnt4;
      @(negedge clk);
      chk("D_busy_after_abort", busy4, 0);
      chk("D_valid_after_abort", res_valid4, 0);
      chk("D_partial_err", err_count4, 28);
      chk("D_partial_sum", sum_ed4, 28);
      repeat (5) @(negedge clk);
      chk("D_no_done", done_cnt4, dc);
      chk("D_metrics_hold", longint'({err_count4, max_ed4, sum_ed4}), longint'(28) * 65536 + 1 * 4096 + 28);

      // Run E: restart, ignored start in RUN, reset while held in DRAIN
      ready_mode = 2;
      start4_pulse();
      @(negedge clk);
      chk("E_ops_restart", longint'({op_a4, op_b4}), 0);
      chk("E_metrics_cleared", longint'({err_count4, max_ed4, sum_ed4}), 0);
      repeat (20) @(posedge clk);
      #1 start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      found = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (busy4 && res_valid4 && res_a4 == 4'd15 && res_b4 == 4'd15) begin found = 1; break; end
      end
      chk("E_last_pair_seen", found, 1);
      repeat (3) @(negedge clk);
      chk("E_held_in_drain", longint'({busy4, res_valid4}), 3);
      chk("E_stream_pos", sb_k, N4 - 1);
      chk("E_no_done", done_cnt4, dc);
      sb_en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("drain_reset");
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
